// File: rtl/sqrt_iter_if.sv
// Operand/result bundle for the iterative square-root unit.
interface sqrt_iter_if #(
  parameter int unsigned DATA_LEN = 32
);
  logic [DATA_LEN-1:0]   in;
  logic [DATA_LEN/2-1:0] out;
  logic [DATA_LEN/2:0]   rout;
  logic                  done;

  modport master (output in, input out, rout, done);
  modport slave  (input in, output out, rout, done);
endinterface

// File: rtl/sqrt_iter.sv
// Restoring digit-by-digit integer square root with remainder, one root bit per clock.
// A new computation starts automatically whenever the operand differs from the latched one.
module sqrt_iter #(
  parameter int unsigned DATA_LEN = 32
) (
  input logic       clk,
  input logic       reset,
  sqrt_iter_if.slave bus
);
  localparam int unsigned H  = DATA_LEN / 2;
  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t              state;
  logic [DATA_LEN-1:0] op_q;
  logic [DATA_LEN-1:0] sh_q;
  logic [H-1:0]        q;
  logic [H:0]          r;
  logic [CW-1:0]       count;

  logic [H+2:0]        r_shift;
  logic [H+1:0]        sub;
  logic                take;
  logic [H-1:0]        q_next;
  logic [H:0]          r_next;

  // The trial subtraction is kept H+1 bits wide: whenever it is taken the
  // result is bounded by 2*q, so the truncated difference is exact.
  always_comb begin
    r_shift = {r, sh_q[DATA_LEN-1 -: 2]};
    sub     = {q, 2'b01};
    take    = (r_shift >= {1'b0, sub});
    q_next  = {q[H-2:0], take};
    r_next  = r_shift[H:0];
    if (take) begin
      r_next = r_shift[H:0] - sub[H:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      count    <= '0;
      op_q     <= '0;
      sh_q     <= '0;
      q        <= '0;
      r        <= '0;
      bus.out  <= '0;
      bus.rout <= '0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          op_q  <= bus.in;
          sh_q  <= bus.in;
          q     <= '0;
          r     <= '0;
          count <= '0;
          state <= RUN;
        end
        RUN: begin
          q     <= q_next;
          r     <= r_next;
          sh_q  <= {sh_q[DATA_LEN-3:0], 2'b00};
          count <= count + CW'(1);
          if (count == LAST) begin
            bus.out  <= q_next;
            bus.rout <= r_next;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.in != op_q) begin
            bus.done <= 1'b0;
            state    <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_iter.sv
// Directed and randomised checks of sqrt_iter results, latency, restart and reset behaviour.
module tb_sqrt_iter;
  logic clk;
  logic reset;
  int   checks;
  int   passed;

  sqrt_iter_if #(.DATA_LEN(32)) bus ();

  sqrt_iter #(.DATA_LEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (bus.done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    bus.in = 32'd140;
    tick();
    tick();
    checks++; if (bus.out !== 16'd0) $display("FAIL reset_out got %0d want 0", bus.out); else passed++;
    checks++; if (bus.rout !== 17'd0) $display("FAIL reset_rout got %0d want 0", bus.rout); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
    reset = 1'b0;
    // first edge after release latches the operand; done follows 16 edges later
    repeat (16) tick();
    checks++; if (bus.done !== 1'b0) $display("FAIL latency_early done got %b want 0", bus.done); else passed++;
    tick();
    checks++; if (bus.done !== 1'b1) $display("FAIL latency done got %b want 1", bus.done); else passed++;
    checks++; if (bus.out !== 16'd11) $display("FAIL sqrt140_out got %0d want 11", bus.out); else passed++;
    checks++; if (bus.rout !== 17'd19) $display("FAIL sqrt140_rout got %0d want 19", bus.rout); else passed++;
  endtask

  task automatic test_done_restart;
    int n;
    bit ok;
    bus.in = 32'd2048;
    tick();
    checks++; if (bus.done !== 1'b0) $display("FAIL restart_drop done got %b want 0", bus.done); else passed++;
    wait_done(40, n, ok);
    checks++; if (!ok || n != 17) $display("FAIL restart_latency got %0d edges (ok=%0d) want 17", n, ok); else passed++;
    checks++; if (bus.out !== 16'd45) $display("FAIL sqrt2048_out got %0d want 45", bus.out); else passed++;
    checks++; if (bus.rout !== 17'd23) $display("FAIL sqrt2048_rout got %0d want 23", bus.rout); else passed++;
  endtask

  task automatic test_boundaries;
    logic [31:0] ops  [3] = '{32'd9216, 32'd0, 32'hFFFF_FFFF};
    logic [15:0] outs [3] = '{16'd96, 16'd0, 16'd65535};
    logic [16:0] routs[3] = '{17'd0, 17'd0, 17'h1FFFE};
    int n;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      bus.in = ops[i];
      tick();
      checks++; if (bus.done !== 1'b0) $display("FAIL bound_drop[%0d] done got %b want 0", i, bus.done); else passed++;
      wait_done(40, n, ok);
      checks++; if (!ok) $display("FAIL bound_timeout[%0d] op=%h no done within 40 edges", i, ops[i]); else passed++;
      checks++; if (bus.out !== outs[i]) $display("FAIL bound_out[%0d] op=%h got %0d want %0d", i, ops[i], bus.out, outs[i]); else passed++;
      checks++; if (bus.rout !== routs[i]) $display("FAIL bound_rout[%0d] op=%h got %h want %h", i, ops[i], bus.rout, routs[i]); else passed++;
    end
  endtask

  task automatic test_mid_run;
    int n;
    bit ok;
    bus.in = 32'd140;
    tick();
    tick();
    repeat (5) tick();
    bus.in = 32'd9216;
    wait_done(20, n, ok);
    checks++; if (!ok || n != 11) $display("FAIL midrun_stale_latency got %0d edges (ok=%0d) want 11", n, ok); else passed++;
    checks++; if (bus.out !== 16'd11) $display("FAIL midrun_stale_out got %0d want 11", bus.out); else passed++;
    checks++; if (bus.rout !== 17'd19) $display("FAIL midrun_stale_rout got %0d want 19", bus.rout); else passed++;
    tick();
    checks++; if (bus.done !== 1'b0) $display("FAIL midrun_pulse done got %b want 0", bus.done); else passed++;
    wait_done(40, n, ok);
    checks++; if (!ok || n != 17) $display("FAIL midrun_restart_latency got %0d edges (ok=%0d) want 17", n, ok); else passed++;
    checks++; if (bus.out !== 16'd96) $display("FAIL midrun_out got %0d want 96", bus.out); else passed++;
    checks++; if (bus.rout !== 17'd0) $display("FAIL midrun_rout got %0d want 0", bus.rout); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    bus.in = 32'd2048;
    tick();
    tick();
    repeat (8) tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.out !== 16'd0) $display("FAIL abort_out got %0d want 0", bus.out); else passed++;
    checks++; if (bus.rout !== 17'd0) $display("FAIL abort_rout got %0d want 0", bus.rout); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done); else passed++;
    reset = 1'b0;
    wait_done(40, n, ok);
    checks++; if (!ok || n != 17) $display("FAIL abort_recompute_latency got %0d edges (ok=%0d) want 17", n, ok); else passed++;
    checks++; if (bus.out !== 16'd45) $display("FAIL abort_out2 got %0d want 45", bus.out); else passed++;
    checks++; if (bus.rout !== 17'd23) $display("FAIL abort_rout2 got %0d want 23", bus.rout); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] prev;
    logic [31:0] v;
    longint unsigned o;
    longint unsigned rr;
    longint unsigned x;
    int n;
    bit ok;
    prev = 32'd2048;
    for (int i = 0; i < 2000; i++) begin
      v = $urandom;
      if (i % 8 == 0) v = v >> (i % 31);
      if (v == prev) v = v ^ 32'd1;
      bus.in = v;
      tick();
      wait_done(40, n, ok);
      o  = longint'(bus.out);
      rr = longint'(bus.rout);
      x  = longint'(v);
      checks++;
      if (!ok) $display("FAIL rand_timeout op=%h no done within 40 edges", v);
      else if (o * o + rr != x || o * o > x || (o + 1) * (o + 1) <= x || rr > 2 * o)
        $display("FAIL rand_result op=%0d got out=%0d rout=%0d", v, bus.out, bus.rout);
      else passed++;
      prev = v;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    bus.in = '0;
    test_reset();
    test_done_restart();
    test_boundaries();
    test_mid_run();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
